// File: rtl/core_run_ctrl.sv
// core_run_ctrl: bring-up sequencer for the single-cycle xgriscv core.
// Streams a program image into instruction memory, releases the core from
// reset, then watches the writeback PC for a halt address while counting
// run cycles against an optional limit. The core is held in reset whenever
// the controller is not in RUN.
module core_run_ctrl #(
   parameter int IMEM_AW = 8,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start,
   input  logic               load_valid,
   input  logic [31:0]        load_data,
   input  logic               load_last,
   output logic               load_ready,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_waddr,
   output logic [31:0]        imem_wdata,
   output logic               core_rstn,
   input  logic [31:0]        pc_w,
   input  logic [31:0]        halt_pc,
   input  logic [CNT_W-1:0]   max_cycles,
   output logic [CNT_W-1:0]   cycle_cnt,
   output logic [2:0]         state,
   output logic               done,
   output logic               timeout,
   output logic               load_err
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_RELEASE = 3'd2,
      S_RUN     = 3'd3,
      S_HALT    = 3'd4,
      S_TIMEOUT = 3'd5,
      S_ERROR   = 3'd6
   } st_t;

   st_t               st;
   logic [IMEM_AW-1:0] widx;      // next instruction-memory word to write

   logic accept;                  // word handshake this cycle
   logic idx_full;                // widx points at the last legal word
   logic halt_hit;                // halt compare, masked in the first RUN cycle
   logic lim_hit;                 // run-cycle limit reached
   logic cnt_sat;                 // counter pinned at all-ones
   logic can_start;               // start is honoured in this state

   assign accept    = load_valid && load_ready;
   assign idx_full  = (widx == {IMEM_AW{1'b1}});
   assign halt_hit  = (cycle_cnt != '0) && (pc_w == halt_pc);
   assign lim_hit   = (max_cycles != '0) && (cycle_cnt == max_cycles);
   assign cnt_sat   = &cycle_cnt;
   assign can_start = (st == S_IDLE) || (st == S_HALT) ||
                      (st == S_TIMEOUT) || (st == S_ERROR);

   assign state = st;

   // Sequencer FSM; every output is a register updated here.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st         <= S_IDLE;
         widx       <= '0;
         load_ready <= 1'b0;
         imem_we    <= 1'b0;
         imem_waddr <= '0;
         imem_wdata <= '0;
         core_rstn  <= 1'b0;
         cycle_cnt  <= '0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         // write strobe is a single-cycle pulse following each accept
         imem_we <= 1'b0;

         if (can_start && start) begin
            st         <= S_LOAD;
            load_ready <= 1'b1;
            widx       <= '0;
            cycle_cnt  <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            load_err   <= 1'b0;
            core_rstn  <= 1'b0;
         end else begin
            unique case (st)
               S_LOAD: begin
                  if (accept) begin
                     imem_we    <= 1'b1;
                     imem_waddr <= widx;
                     imem_wdata <= load_data;
                     if (load_last) begin
                        // last word wins even on the final legal index
                        st         <= S_RELEASE;
                        load_ready <= 1'b0;
                     end else if (idx_full) begin
                        // image longer than memory; index does not wrap
                        st         <= S_ERROR;
                        load_ready <= 1'b0;
                        load_err   <= 1'b1;
                     end else begin
                        widx <= widx + 1'b1;
                     end
                  end
               end

               S_RELEASE: begin
                  // one quiet cycle lets the final write land before the core runs
                  st        <= S_RUN;
                  core_rstn <= 1'b1;
                  cycle_cnt <= '0;
               end

               S_RUN: begin
                  if (halt_hit) begin
                     st        <= S_HALT;
                     done      <= 1'b1;
                     core_rstn <= 1'b0;
                  end else if (lim_hit) begin
                     st        <= S_TIMEOUT;
                     timeout   <= 1'b1;
                     core_rstn <= 1'b0;
                  end else if (!cnt_sat) begin
                     cycle_cnt <= cycle_cnt + 1'b1;
                  end
               end

               S_IDLE, S_HALT, S_TIMEOUT, S_ERROR: begin
                  // terminal until the next start
                  load_ready <= 1'b0;
                  core_rstn  <= 1'b0;
               end

               default: begin
                  st         <= S_IDLE;
                  load_ready <= 1'b0;
                  core_rstn  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: load, halt, timeout, overflow with
// backpressure gaps, halt/timeout priority, ignored start and async reset.
module tb_core_run_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   always #5 clk = ~clk;

   // main instance (IMEM_AW=8)
   logic        start, lv, ll, lr, we, crst, done, tmo, lerr;
   logic [31:0] ld, wd, pc_w, halt_pc;
   logic [7:0]  wa;
   logic [15:0] maxc, cnt;
   logic [2:0]  st;

   // overflow instance (IMEM_AW=2)
   logic        start2, lv2, ll2, lr2, we2, crst2, done2, tmo2, lerr2;
   logic [31:0] ld2, wd2;
   logic [1:0]  wa2;
   logic [15:0] cnt2;
   logic [2:0]  st2;

   core_run_ctrl #(.IMEM_AW(8), .CNT_W(16)) u_dut (
      .clk(clk), .rstn(rstn), .start(start),
      .load_valid(lv), .load_data(ld), .load_last(ll), .load_ready(lr),
      .imem_we(we), .imem_waddr(wa), .imem_wdata(wd), .core_rstn(crst),
      .pc_w(pc_w), .halt_pc(halt_pc), .max_cycles(maxc), .cycle_cnt(cnt),
      .state(st), .done(done), .timeout(tmo), .load_err(lerr)
   );

   core_run_ctrl #(.IMEM_AW(2), .CNT_W(16)) u_dut2 (
      .clk(clk), .rstn(rstn), .start(start2),
      .load_valid(lv2), .load_data(ld2), .load_last(ll2), .load_ready(lr2),
      .imem_we(we2), .imem_waddr(wa2), .imem_wdata(wd2), .core_rstn(crst2),
      .pc_w(pc_w), .halt_pc(halt_pc), .max_cycles(maxc), .cycle_cnt(cnt2),
      .state(st2), .done(done2), .timeout(tmo2), .load_err(lerr2)
   );

   int errors = 0;
   int checks = 0;

   logic [31:0] prog [4] = '{32'h00000293, 32'h00000313, 32'hFFFFF3B7, 32'h00000013};
   logic [31:0] ov   [6] = '{32'hA0000000, 32'hA1111111, 32'hA2222222,
                             32'hA3333333, 32'hA4444444, 32'hA5555555};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // start, stream prog[0..n-1] back-to-back, end at the first RUN negedge
   task automatic load_run(input int n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("load_state", 32'(st), 32'd1);
      chk("load_ready", 32'(lr), 32'd1);
      chk("load_clr_done", 32'(done), 32'd0);
      chk("load_clr_tmo", 32'(tmo), 32'd0);
      for (int i = 0; i < n; i++) begin
         lv = 1'b1;
         ld = prog[i];
         ll = (i == n - 1);
         @(negedge clk);
         chk("wr_we", 32'(we), 32'd1);
         chk("wr_addr", 32'(wa), 32'(i));
         chk("wr_data", wd, prog[i]);
      end
      lv = 1'b0;
      ll = 1'b0;
      chk("rel_state", 32'(st), 32'd2);
      chk("rel_core_rstn", 32'(crst), 32'd0);
      chk("rel_ready", 32'(lr), 32'd0);
      @(negedge clk);
      chk("run_state", 32'(st), 32'd3);
      chk("run_core_rstn", 32'(crst), 32'd1);
      chk("run_cnt0", 32'(cnt), 32'd0);
      chk("run_we", 32'(we), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [11:0] pat;
      int          sent;
      logic        acc;
      logic        crst2_seen;

      start = 0; lv = 0; ld = 0; ll = 0;
      start2 = 0; lv2 = 0; ld2 = 0; ll2 = 0;
      pc_w = 0; halt_pc = 32'h000000ff; maxc = 0;

      // reset state
      #12;
      chk("rst_state", 32'(st), 32'd0);
      chk("rst_core_rstn", 32'(crst), 32'd0);
      chk("rst_ready", 32'(lr), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_cnt", 32'(cnt), 32'd0);
      chk("rst_flags", {29'd0, done, tmo, lerr}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("idle_state", 32'(st), 32'd0);

      // load 4 words then halt at cycle 10; PC equals halt_pc at cnt 0 to test masking
      load_run(4);
      pc_w = 32'h000000ff;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         chk("halt_cnt", 32'(cnt), 32'(k));
         pc_w = (k == 10) ? 32'h000000ff : 32'(4 * k);
      end
      @(negedge clk);
      chk("halt_state", 32'(st), 32'd4);
      chk("halt_done", 32'(done), 32'd1);
      chk("halt_tmo", 32'(tmo), 32'd0);
      chk("halt_cnt_hold", 32'(cnt), 32'd10);
      chk("halt_core_rstn", 32'(crst), 32'd0);
      pc_w = 32'd0;
      @(negedge clk);
      chk("halt_sticky", 32'(st), 32'd4);
      chk("halt_cnt_frozen", 32'(cnt), 32'd10);

      // timeout at 20 with no PC match
      prog[0] = 32'h00000013;
      maxc = 16'd20;
      load_run(1);
      repeat (20) @(negedge clk);
      chk("tmo_pre_state", 32'(st), 32'd3);
      chk("tmo_pre_cnt", 32'(cnt), 32'd20);
      @(negedge clk);
      chk("tmo_state", 32'(st), 32'd5);
      chk("tmo_flag", 32'(tmo), 32'd1);
      chk("tmo_done", 32'(done), 32'd0);
      chk("tmo_cnt", 32'(cnt), 32'd20);
      chk("tmo_core_rstn", 32'(crst), 32'd0);

      // halt and limit on the same cycle, plus a start pulse during RUN
      maxc = 16'd5;
      load_run(1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk("pri_cnt", 32'(cnt), 32'(k));
         if (k == 3) chk("pri_start_ignored", 32'(st), 32'd3);
         start = (k == 2);
         pc_w  = (k == 5) ? 32'h000000ff : 32'd0;
      end
      start = 1'b0;
      @(negedge clk);
      chk("pri_state", 32'(st), 32'd4);
      chk("pri_done", 32'(done), 32'd1);
      chk("pri_tmo", 32'(tmo), 32'd0);
      chk("pri_cnt_hold", 32'(cnt), 32'd5);
      pc_w = 32'd0;

      // asynchronous reset mid-RUN, checked before the next clock edge
      maxc = 16'd0;
      load_run(1);
      repeat (3) @(negedge clk);
      chk("ar_pre_state", 32'(st), 32'd3);
      #2 rstn = 1'b0;
      #1;
      chk("ar_state", 32'(st), 32'd0);
      chk("ar_core_rstn", 32'(crst), 32'd0);
      chk("ar_cnt", 32'(cnt), 32'd0);
      chk("ar_wdata", wd, 32'd0);
      chk("ar_flags", {29'd0, done, tmo, lerr}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      chk("ar_idle", 32'(st), 32'd0);
      chk("ar_idle_core", 32'(crst), 32'd0);

      // overflow on the 4-word instance, valid with gaps, no last
      pat  = 12'b110111001101;   // slot i uses pat[i]: 1,0,1,1,0,0,1,1,1,0,1,1
      sent = 0;
      crst2_seen = 1'b0;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      chk("ov_load_state", 32'(st2), 32'd1);
      for (int i = 0; i < 14; i++) begin
         lv2 = (i < 12) ? pat[i] : 1'b0;
         ld2 = ov[(sent < 6) ? sent : 5];
         ll2 = 1'b0;
         acc = lv2 && (sent < 4);
         @(negedge clk);
         chk("ov_we", 32'(we2), 32'(acc));
         if (acc) begin
            chk("ov_addr", 32'(wa2), 32'(sent));
            chk("ov_data", wd2, ov[sent]);
            sent++;
         end
         if (crst2 !== 1'b0) crst2_seen = 1'b1;
      end
      lv2 = 1'b0;
      chk("ov_writes", 32'(sent), 32'd4);
      chk("ov_state", 32'(st2), 32'd6);
      chk("ov_err", 32'(lerr2), 32'd1);
      chk("ov_ready", 32'(lr2), 32'd0);
      chk("ov_core_never", 32'(crst2_seen), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
